// File: rtl/act_interp_pipe.sv
// rtl/act_interp_pipe.sv - three-stage table-interpolated activation unit
// Maps signed x to a table segment, outputs base + slope*rem (or base in step mode).
module act_interp_pipe #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 4,
    localparam int ADDR = WIDTH - FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_step,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             lut_we,
    input  logic [ADDR-1:0]  lut_addr,
    input  logic [WIDTH-1:0] lut_wdata
);

    localparam int DEPTH = 1 << ADDR;
    localparam int PW    = WIDTH + FRAC + 2;
    localparam logic [ADDR-1:0] IDX_FLIP = ADDR'(1) << (ADDR - 1);

    logic [WIDTH-1:0] lut_q [DEPTH];

    logic                   enable;
    logic [ADDR-1:0]        idx;
    logic [ADDR-1:0]        next_idx;

    logic                   s1_valid_q;
    logic [WIDTH-1:0]       s1_base_q;
    logic [WIDTH-1:0]       s1_next_q;
    logic [FRAC-1:0]        s1_rem_q;
    logic                   s1_step_q;

    logic [WIDTH:0]         s2_diff;
    logic signed [PW-1:0]   s2_prod_d;
    logic                   s2_valid_q;
    logic [WIDTH-1:0]       s2_base_q;
    logic signed [PW-1:0]   s2_prod_q;
    logic                   s2_step_q;

    logic [WIDTH-1:0]       out_data_d;
    logic                   out_valid_q;
    logic [WIDTH-1:0]       out_data_q;

    // Whole pipe moves in lockstep; bubbles are kept, not squeezed out.
    assign enable    = !out_valid_q | out_ready;
    assign in_ready  = enable;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Offset-binary segment index: most negative x lands on entry 0.
    assign idx      = in_data[WIDTH-1:FRAC] ^ IDX_FLIP;
    assign next_idx = (&idx) ? idx : idx + 1'b1;

    // Table has no reset; a same-cycle write is seen only by later samples.
    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut_q[lut_addr] <= lut_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_base_q  <= '0;
            s1_next_q  <= '0;
            s1_rem_q   <= '0;
            s1_step_q  <= 1'b0;
        end else if (enable) begin
            s1_valid_q <= in_valid;
            s1_base_q  <= lut_q[idx];
            s1_next_q  <= lut_q[next_idx];
            s1_rem_q   <= in_data[FRAC-1:0];
            s1_step_q  <= in_step;
        end
    end

    always_comb begin
        s2_diff   = {s1_next_q[WIDTH-1], s1_next_q} - {s1_base_q[WIDTH-1], s1_base_q};
        s2_prod_d = $signed({{(PW-WIDTH-1){s2_diff[WIDTH]}}, s2_diff})
                  * $signed({{(PW-FRAC){1'b0}}, s1_rem_q});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_base_q  <= '0;
            s2_prod_q  <= '0;
            s2_step_q  <= 1'b0;
        end else if (enable) begin
            s2_valid_q <= s1_valid_q;
            s2_base_q  <= s1_base_q;
            s2_prod_q  <= s2_prod_d;
            s2_step_q  <= s1_step_q;
        end
    end

    // Result lies between base and next, so wrapping to WIDTH is exact.
    always_comb begin
        out_data_d = s2_base_q;
        if (!s2_step_q) begin
            out_data_d = WIDTH'(s2_base_q + WIDTH'(s2_prod_q >>> FRAC));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (enable) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_data_q <= out_data_d;
            end
        end
    end

endmodule

// File: tb/tb_act_interp_pipe.sv
// tb/tb_act_interp_pipe.sv - self-checking bench for act_interp_pipe
module tb_act_interp_pipe;

    localparam int NONE = 9999;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_step = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       lut_we = 1'b0;
    logic [3:0] lut_addr = '0;
    logic [7:0] lut_wdata = '0;

    always #5 clk = ~clk;

    act_interp_pipe #(.WIDTH(8), .FRAC(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_step(in_step),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata)
    );

    typedef struct {
        int val;
        int acc;
        bit lat;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   forced = NONE;
    bit   chk_lat = 1'b0;
    int   ref_lut [16];
    exp_t expq [$];

    // Reference: value of the piecewise-linear curve, floor-rounded.
    function automatic int model(int x, bit step);
        int u, i, r, b, n, p, q;
        u = x + 128;
        i = u / 16;
        r = u % 16;
        b = ref_lut[i];
        n = (i == 15) ? b : ref_lut[i + 1];
        p = (n - b) * r;
        q = p / 16;
        if (p < 0 && (p % 16) != 0) q = q - 1;
        return step ? b : b + q;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step_cycle(output bit acc);
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("spurious_output_valid", out_valid, 0);
            end else begin
                e = expq.pop_front();
                check("out_data", $signed(out_data), e.val);
                if (e.lat) check("latency", cyc - e.acc, 3);
            end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            e.val = (forced != NONE) ? forced : model(int'($signed(in_data)), in_step);
            e.acc = cyc;
            e.lat = chk_lat;
            expq.push_back(e);
        end
        if (lut_we) ref_lut[lut_addr] = int'($signed(lut_wdata));
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int k = 0; k < n; k++) step_cycle(a);
    endtask

    task automatic wr(input int addr, input int d);
        bit a;
        lut_we    = 1'b1;
        lut_addr  = addr[3:0];
        lut_wdata = d[7:0];
        step_cycle(a);
        lut_we    = 1'b0;
    endtask

    task automatic send(input int x, input bit step, input int exp);
        bit a;
        a        = 1'b0;
        in_valid = 1'b1;
        in_data  = x[7:0];
        in_step  = step;
        forced   = exp;
        for (int k = 0; k < 20 && !a; k++) step_cycle(a);
        check("send_accepted", a, 1);
        in_valid = 1'b0;
        forced   = NONE;
    endtask

    initial begin
        bit         a;
        int         nacc;
        bit         have_held;
        logic [7:0] held;

        repeat (2) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", $signed(out_data), 0);
        check("reset_in_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) wr(i, int'($urandom_range(0, 255)) - 128);

        // Directed vectors with no stalls, latency checked.
        chk_lat   = 1'b1;
        out_ready = 1'b1;
        wr(10, 16); wr(11, 48);
        send('h25, 1'b0, 26); idle(4);
        wr(10, 48); wr(11, 16);
        send('h25, 1'b0, 38); idle(4);
        wr(10, 0); wr(11, -1);
        send('h21, 1'b0, -1); idle(4);
        wr(10, 16);
        send('h25, 1'b1, 16);
        wr(15, 100);
        send('h7F, 1'b0, 100);
        wr(0, -128); wr(1, -96);
        send('h80, 1'b0, -128);
        send('h88, 1'b0, -112);
        idle(5);

        // Write and read of the same entry in one cycle, then the next cycle.
        in_valid  = 1'b1; in_data = 8'h20; in_step = 1'b0;
        lut_we    = 1'b1; lut_addr = 4'd10; lut_wdata = 8'd64;
        forced    = 16;
        step_cycle(a);
        check("hazard_old_accepted", a, 1);
        lut_we = 1'b0;
        forced = 64;
        step_cycle(a);
        check("hazard_new_accepted", a, 1);
        in_valid = 1'b0;
        forced   = NONE;
        idle(5);
        check("directed_drained", expq.size(), 0);
        chk_lat = 1'b0;

        // Backpressure: out_ready low from the first result, released later.
        nacc = 0;
        have_held = 1'b0;
        held = '0;
        for (int k = 0; k < 40 && (nacc < 5 || expq.size() > 0); k++) begin
            if (nacc < 5) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                in_step  = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (k >= 8);
            #1;
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 0);
                if (have_held) check("stall_out_data", out_data, held);
                held      = out_data;
                have_held = 1'b1;
            end
            step_cycle(a);
            if (a) nacc++;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", nacc, 5);
        check("bp_all_delivered", expq.size(), 0);
        check("bp_stall_seen", have_held, 1);

        // Random traffic with random stalls and table writes.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom % 2) == 0;
            in_data   = 8'($urandom);
            in_step   = ($urandom % 4) == 0;
            out_ready = ($urandom % 4) != 0;
            lut_we    = ($urandom % 8) == 0;
            lut_addr  = 4'($urandom);
            lut_wdata = 8'($urandom);
            step_cycle(a);
        end
        in_valid  = 1'b0;
        lut_we    = 1'b0;
        out_ready = 1'b1;
        idle(6);
        check("random_drained", expq.size(), 0);

        // Async reset with three samples in flight and out_valid high.
        wr(10, 64);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'($urandom);
            step_cycle(a);
        end
        in_valid = 1'b0;
        #1;
        check("pre_reset_out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_out_data", $signed(out_data), 0);
        check("async_in_ready", in_ready, 1);
        expq.delete();
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        idle(6);
        send('h25, 1'b1, 64);
        idle(5);
        check("post_reset_drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
